// File: rtl/hack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hack_pkg
// Description : Shared definitions for the multi-cycle Hack CPU: FSM state
//               encoding, C-instruction field positions, dest/jump bit names
//               and the jump-condition helper.
// Revision    : 1.0 - initial release
// ============================================================================
package hack_pkg;

    // FSM state encoding
    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_FETCH  = 3'd1;
    localparam logic [STATE_W-1:0] ST_DECODE = 3'd2;
    localparam logic [STATE_W-1:0] ST_READ   = 3'd3;
    localparam logic [STATE_W-1:0] ST_EXEC   = 3'd4;
    localparam logic [STATE_W-1:0] ST_WRITE  = 3'd5;
    localparam logic [STATE_W-1:0] ST_COMMIT = 3'd6;

    // C-instruction field positions (absolute IR bit indices)
    localparam int EXT_HI  = 14;
    localparam int EXT_LO  = 13;
    localparam int A_BIT   = 12;
    localparam int COMP_HI = 11;
    localparam int COMP_LO = 6;
    localparam int DEST_HI = 5;
    localparam int DEST_LO = 3;
    localparam int JUMP_HI = 2;
    localparam int JUMP_LO = 0;

    // Destination bits
    localparam int DEST_A = 5;
    localparam int DEST_D = 4;
    localparam int DEST_M = 3;

    // Jump bits (positions within the 3-bit jump field)
    localparam int JMP_NEG  = 2;
    localparam int JMP_ZERO = 1;
    localparam int JMP_POS  = 0;

    // ALU control word width: {ext[1:0], reserved, comp[5:0]}
    localparam int ALU_CTRL_W = 9;

    function automatic logic jump_taken(input logic [2:0] jmp,
                                        input logic       zr,
                                        input logic       ng);
        return (jmp[JMP_NEG]  & ng) |
               (jmp[JMP_ZERO] & zr) |
               (jmp[JMP_POS]  & ~zr & ~ng);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hack_ext_alu.sv
`default_nettype none
// ============================================================================
// Module      : hack_ext_alu
// Description : Combinational extended Hack ALU.
//               ctrl = {ext[1:0], reserved, comp[5:0]}
//                 ext=11 : classic Hack ALU (zx,nx,zy,ny,f,no)
//                 ext=10 : shift by one; comp[5] selects y (1) or x (0),
//                          comp[4] selects left (1) or logical right (0)
//                 ext=01 : bitwise; comp[1:0] = and / or / xor / nand
//                 ext=00 : subtract; comp[0] ? y-x : x-y
// Ports       : x, y  - operands (x = D, y = A or M)
//               ctrl  - control word
//               out   - result; zr = (out==0); ng = out sign bit
// Revision    : 1.0 - initial release
// ============================================================================
module hack_ext_alu
    import hack_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]      x,
    input  logic [WIDTH-1:0]      y,
    input  logic [ALU_CTRL_W-1:0] ctrl,
    output logic [WIDTH-1:0]      out,
    output logic                  zr,
    output logic                  ng
);

    logic [1:0]       ext;
    logic [5:0]       comp;
    logic             unused_reserved;
    logic [WIDTH-1:0] x1, x2, y1, y2, fn, std_out, shf_src;

    assign ext             = ctrl[8:7];
    assign unused_reserved = ctrl[6];   // always 0 in the current encoding
    assign comp            = ctrl[5:0];

    always_comb begin
        // Classic Hack datapath
        x1      = comp[5] ? '0  : x;
        x2      = comp[4] ? ~x1 : x1;
        y1      = comp[3] ? '0  : y;
        y2      = comp[2] ? ~y1 : y1;
        fn      = comp[1] ? (x2 + y2) : (x2 & y2);
        std_out = comp[0] ? ~fn : fn;
        shf_src = comp[5] ? y : x;

        unique case (ext)
            2'b11: out = std_out;
            2'b10: out = comp[4] ? (shf_src << 1) : (shf_src >> 1);
            2'b01: begin
                unique case (comp[1:0])
                    2'b00:   out = x & y;
                    2'b01:   out = x | y;
                    2'b10:   out = x ^ y;
                    default: out = ~(x & y);
                endcase
            end
            default: out = comp[0] ? (y - x) : (x - y);
        endcase
    end

    assign zr = (out == '0);
    assign ng = out[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/hack_cpu_mc.sv
`default_nettype none
// ============================================================================
// Module      : hack_cpu_mc
// Description : Multi-cycle Hack CPU with req/ack instruction and data ports.
//               FSM: IDLE -> FETCH -> DECODE -> [READ] -> EXEC -> [WRITE]
//               -> COMMIT -> FETCH. A-instructions retire from DECODE.
// Ports       : clk, reset_n (async active-low)
//               imem_req/addr/ack/rdata  - instruction fetch handshake
//               dmem_req/we/addr/wdata/ack/rdata - data access handshake
//               retire - one-cycle commit strobe; pc_o - current PC
// Revision    : 1.0 - initial release
// ============================================================================
module hack_cpu_mc
    import hack_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = WIDTH - 1
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [WIDTH-1:0]  imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [WIDTH-1:0]  dmem_wdata,
    input  logic              dmem_ack,
    input  logic [WIDTH-1:0]  dmem_rdata,
    output logic              retire,
    output logic [ADDR_W-1:0] pc_o
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  d_q, d_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [WIDTH-1:0]  ir_q, ir_d;
    logic [WIDTH-1:0]  m_q, m_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              jmp_q, jmp_d;

    logic                  is_c;
    logic [WIDTH-1:0]      alu_y, alu_out;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic                  alu_zr, alu_ng;
    logic [ADDR_W-1:0]     pc_inc;

    assign is_c     = ir_q[WIDTH-1];
    assign alu_y    = ir_q[A_BIT] ? m_q : a_q;
    assign alu_ctrl = {ir_q[EXT_HI:EXT_LO], 1'b0, ir_q[COMP_HI:COMP_LO]};
    assign pc_inc   = pc_q + ADDR_ONE;   // wraps naturally at all-ones

    hack_ext_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .x    (d_q),
        .y    (alu_y),
        .ctrl (alu_ctrl),
        .out  (alu_out),
        .zr   (alu_zr),
        .ng   (alu_ng)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        d_d     = d_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        m_d     = m_q;
        res_d   = res_q;
        jmp_d   = jmp_q;

        unique case (state_q)
            ST_IDLE: state_d = ST_FETCH;

            ST_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                if (!is_c) begin
                    a_d     = {1'b0, ir_q[WIDTH-2:0]};
                    pc_d    = pc_inc;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ir_q[A_BIT] ? ST_READ : ST_EXEC;
                end
            end

            ST_READ: begin
                if (dmem_ack) begin
                    m_d     = dmem_rdata;
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                res_d   = alu_out;
                jmp_d   = jump_taken(ir_q[JUMP_HI:JUMP_LO], alu_zr, alu_ng);
                state_d = ir_q[DEST_M] ? ST_WRITE : ST_COMMIT;
            end

            ST_WRITE: begin
                if (dmem_ack) state_d = ST_COMMIT;
            end

            ST_COMMIT: begin
                // A is still the pre-commit value here, so a jump targets
                // the old A even when A is also a destination.
                if (ir_q[DEST_D]) d_d = res_q;
                if (ir_q[DEST_A]) a_d = res_q;
                pc_d    = jmp_q ? a_q[ADDR_W-1:0] : pc_inc;
                state_d = ST_FETCH;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            d_q     <= '0;
            pc_q    <= '0;
            ir_q    <= '0;
            m_q     <= '0;
            res_q   <= '0;
            jmp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            d_q     <= d_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            m_q     <= m_d;
            res_q   <= res_d;
            jmp_q   <= jmp_d;
        end
    end

    // Outputs decode straight from registered state, so they drop the
    // moment reset is asserted and are stable for a whole request.
    assign imem_req   = (state_q == ST_FETCH);
    assign imem_addr  = pc_q;
    assign dmem_req   = (state_q == ST_READ) || (state_q == ST_WRITE);
    assign dmem_we    = (state_q == ST_WRITE);
    assign dmem_addr  = a_q[ADDR_W-1:0];
    assign dmem_wdata = res_q;
    assign retire     = ((state_q == ST_DECODE) && !is_c) || (state_q == ST_COMMIT);
    assign pc_o       = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_hack_cpu_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_hack_cpu_mc
// Description : Scoreboard bench for hack_cpu_mc. Expected retires and data
//               accesses are queued up front; monitors pop and compare as
//               the DUT presents them. A 16-bit and a 24-bit instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hack_cpu_mc;

    localparam int K_RET = 0;
    localparam int K_RD  = 1;
    localparam int K_WR  = 2;

    typedef struct {
        int          kind;
        logic [14:0] addr;
        logic [15:0] data;
        logic [14:0] pc;
        logic [15:0] a;
        logic [15:0] d;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event not expected or not reached", name);
    endtask

    // ---------------- 16-bit instance ----------------
    logic        reset_n16 = 1'b0;
    logic        imem_req16, dmem_req16, dmem_we16, retire16;
    logic [14:0] imem_addr16, dmem_addr16, pc16;
    logic [15:0] dmem_wdata16;
    logic        imem_ack16 = 1'b0, dmem_ack16 = 1'b0;
    logic [15:0] imem_rdata16 = '0, dmem_rdata16 = '0;

    hack_cpu_mc #(.WIDTH(16)) u16 (
        .clk        (clk),
        .reset_n    (reset_n16),
        .imem_req   (imem_req16),
        .imem_addr  (imem_addr16),
        .imem_ack   (imem_ack16),
        .imem_rdata (imem_rdata16),
        .dmem_req   (dmem_req16),
        .dmem_we    (dmem_we16),
        .dmem_addr  (dmem_addr16),
        .dmem_wdata (dmem_wdata16),
        .dmem_ack   (dmem_ack16),
        .dmem_rdata (dmem_rdata16),
        .retire     (retire16),
        .pc_o       (pc16)
    );

    logic [15:0] prog [0:31];
    int          dlat [0:31];
    logic [15:0] dmem_arr [0:127];
    bit          force_ack = 0;
    bit          mon_en = 0;
    exp_t        q[$];

    // Instruction memory: zero-wait
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (imem_req16 && reset_n16) begin
                imem_ack16   = 1'b1;
                imem_rdata16 = prog[imem_addr16[4:0]];
            end else begin
                imem_ack16 = 1'b0;
            end
            if (force_ack) imem_ack16 = 1'b1;
        end
    end

    // Data memory: wait states chosen per instruction address
    initial begin
        int dcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (dmem_req16 && reset_n16) begin
                if (dcnt >= dlat[pc16[4:0]]) begin
                    dmem_ack16   = 1'b1;
                    dmem_rdata16 = dmem_arr[dmem_addr16[6:0]];
                    dcnt         = 0;
                end else begin
                    dmem_ack16 = 1'b0;
                    dcnt++;
                end
            end else begin
                dmem_ack16 = 1'b0;
                dcnt       = 0;
            end
            if (force_ack) dmem_ack16 = 1'b1;
        end
    end

    // Monitor / scoreboard for the 16-bit instance
    initial begin
        int   cyc = 0;
        int   ack_cyc = 0;
        bit   pend = 0;
        exp_t pe;
        exp_t f;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                if (pend) begin
                    chk("pc_after_retire", 64'(pc16), 64'(pe.pc));
                    chk("a_after_retire", 64'(u16.a_q), 64'(pe.a));
                    chk("d_after_retire", 64'(u16.d_q), 64'(pe.d));
                    pend = 0;
                end
                if (imem_req16 && imem_ack16) ack_cyc = cyc;
                if (dmem_req16) begin
                    if (q.size() == 0 || q[0].kind == K_RET) begin
                        fail("unexpected_dmem_req");
                    end else begin
                        f = q[0];
                        chk("dmem_bus",
                            64'({dmem_we16, dmem_addr16, (dmem_we16 ? dmem_wdata16 : 16'h0)}),
                            64'({(f.kind == K_WR), f.addr, f.data}));
                        if (dmem_ack16) void'(q.pop_front());
                    end
                end
                if (retire16) begin
                    if (q.size() == 0 || q[0].kind != K_RET) begin
                        fail("unexpected_retire");
                    end else begin
                        pe = q.pop_front();
                        chk("retire_latency", 64'(cyc - ack_cyc), 64'(pe.lat));
                        pend = 1;
                    end
                end
            end else begin
                pend = 0;
            end
        end
    end

    task automatic exp_ret(input logic [14:0] pc, input logic [15:0] a,
                           input logic [15:0] d, input int lat);
        exp_t e;
        e.kind = K_RET; e.addr = '0; e.data = '0;
        e.pc = pc; e.a = a; e.d = d; e.lat = lat;
        q.push_back(e);
    endtask

    task automatic exp_mem(input int kind, input logic [14:0] addr, input logic [15:0] data);
        exp_t e;
        e.kind = kind; e.addr = addr; e.data = data;
        e.pc = '0; e.a = '0; e.d = '0; e.lat = 0;
        q.push_back(e);
    endtask

    // ---------------- 24-bit instance ----------------
    logic        reset_n24 = 1'b0;
    logic        imem_req24, dmem_req24, dmem_we24, retire24;
    logic [22:0] imem_addr24, dmem_addr24, pc24;
    logic [23:0] dmem_wdata24, imem_rdata24;
    logic        imem_ack24, dmem_ack24;
    logic [23:0] dmem_rdata24;
    logic [22:0] q24[$];
    logic [22:0] exp24;
    bit          pend24 = 0;

    function automatic logic [23:0] rom24(input logic [22:0] a);
        case (a)
            23'h000000: return 24'h3FFFFF;   // @0x3FFFFF
            23'h000001: return 24'h806A87;   // 0;JMP
            23'h3FFFFF: return 24'h7FFFFF;   // @0x7FFFFF
            23'h400000: return 24'h806A87;   // 0;JMP
            23'h7FFFFF: return 24'h000001;   // @1, PC wraps to 0
            default:    return 24'h000000;
        endcase
    endfunction

    assign imem_ack24   = imem_req24;
    assign imem_rdata24 = rom24(imem_addr24);
    assign dmem_ack24   = dmem_req24;
    assign dmem_rdata24 = '0;

    hack_cpu_mc #(.WIDTH(24)) u24 (
        .clk        (clk),
        .reset_n    (reset_n24),
        .imem_req   (imem_req24),
        .imem_addr  (imem_addr24),
        .imem_ack   (imem_ack24),
        .imem_rdata (imem_rdata24),
        .dmem_req   (dmem_req24),
        .dmem_we    (dmem_we24),
        .dmem_addr  (dmem_addr24),
        .dmem_wdata (dmem_wdata24),
        .dmem_ack   (dmem_ack24),
        .dmem_rdata (dmem_rdata24),
        .retire     (retire24),
        .pc_o       (pc24)
    );

    initial begin
        forever begin
            @(negedge clk);
            if (reset_n24) begin
                if (pend24) begin
                    chk("pc24_after_retire", 64'(pc24), 64'(exp24));
                    pend24 = 0;
                end
                if (retire24 && q24.size() > 0) begin
                    exp24  = q24.pop_front();
                    pend24 = 1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit reached;

        for (int i = 0; i < 32; i++) begin
            prog[i] = 16'h0000;
            dlat[i] = 0;
        end
        for (int i = 0; i < 128; i++) dmem_arr[i] = 16'h0000;
        prog[0]  = 16'h0005;  // @5
        prog[1]  = 16'h0007;  // @7
        prog[2]  = 16'hEC10;  // D=A
        prog[3]  = 16'hE7C8;  // M=D+1
        prog[4]  = 16'h0064;  // @100
        prog[5]  = 16'hFC10;  // D=M
        prog[6]  = 16'h000C;  // @12
        prog[7]  = 16'hE304;  // D;JLT
        prog[12] = 16'hE301;  // D;JGT
        prog[13] = 16'h0009;  // @9
        prog[14] = 16'hEEA8;  // AM=-1
        prog[15] = 16'h0055;  // @0x55
        prog[16] = 16'hEC10;  // D=A
        prog[17] = 16'h0014;  // @20
        prog[18] = 16'hE308;  // M=D (never acked; reset lands here)
        dlat[3]  = 3;
        dlat[18] = 1000;
        dmem_arr[100] = 16'hFFFF;

        exp_ret(15'd1,  16'd5,   16'd0,   1);
        exp_ret(15'd2,  16'd7,   16'd0,   1);
        exp_ret(15'd3,  16'd7,   16'd7,   3);
        exp_mem(K_WR,   15'd7,   16'd8);
        exp_ret(15'd4,  16'd7,   16'd7,   7);
        exp_ret(15'd5,  16'd100, 16'd7,   1);
        exp_mem(K_RD,   15'd100, 16'd0);
        exp_ret(15'd6,  16'd100, 16'hFFFF, 4);
        exp_ret(15'd7,  16'd12,  16'hFFFF, 1);
        exp_ret(15'd12, 16'd12,  16'hFFFF, 3);
        exp_ret(15'd13, 16'd12,  16'hFFFF, 3);
        exp_ret(15'd14, 16'd9,   16'hFFFF, 1);
        exp_mem(K_WR,   15'd9,   16'hFFFF);
        exp_ret(15'd15, 16'hFFFF, 16'hFFFF, 4);
        exp_ret(15'd16, 16'h0055, 16'hFFFF, 1);
        exp_ret(15'd17, 16'h0055, 16'h0055, 3);
        exp_ret(15'd18, 16'd20,  16'h0055, 1);
        exp_mem(K_WR,   15'd20,  16'h0055);

        q24.push_back(23'h000001);
        q24.push_back(23'h3FFFFF);
        q24.push_back(23'h400000);
        q24.push_back(23'h7FFFFF);
        q24.push_back(23'h000000);

        // Reset: every output low
        repeat (3) @(negedge clk);
        chk("outputs_in_reset",
            64'({imem_req16, dmem_req16, dmem_we16, retire16,
                 imem_addr16, dmem_addr16, dmem_wdata16, pc16}), 64'h0);

        // Release just after a posedge: one IDLE cycle, then FETCH
        mon_en = 1;
        @(posedge clk);
        #1 reset_n16 = 1'b1;
        @(negedge clk);
        chk("imem_req_cycle1", 64'(imem_req16), 64'h0);
        @(negedge clk);
        chk("imem_req_cycle2", 64'({imem_req16, imem_addr16}), 64'({1'b1, 15'd0}));

        // Run the program until the final write is pending
        reached = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (q.size() == 1 && dmem_req16 && dmem_we16) begin
                reached = 1;
                break;
            end
        end
        if (!reached) fail("timeout_program16");
        repeat (3) @(negedge clk);

        // Reset during WRITE: request drops at once, state cleared
        #1;
        mon_en    = 0;
        reset_n16 = 1'b0;
        #1;
        chk("dmem_req_drop", 64'({dmem_req16, dmem_we16}), 64'h0);
        chk("d_pc_cleared", 64'({u16.d_q, pc16}), 64'h0);
        q.delete();
        force_ack = 1;
        repeat (2) @(negedge clk);
        chk("ack_during_reset",
            64'({imem_req16, dmem_req16, retire16, pc16, u16.a_q, u16.d_q}), 64'h0);
        force_ack = 0;
        @(negedge clk);
        @(posedge clk);
        #1 reset_n16 = 1'b1;
        @(negedge clk);
        chk("rerun_imem_req_cycle1", 64'(imem_req16), 64'h0);
        @(negedge clk);
        chk("rerun_imem_req_cycle2", 64'({imem_req16, imem_addr16}), 64'({1'b1, 15'd0}));

        // 24-bit instance: jump to 0x3FFFFF, then to all-ones and wrap
        @(posedge clk);
        #1 reset_n24 = 1'b1;
        reached = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (q24.size() == 0 && !pend24) begin
                reached = 1;
                break;
            end
        end
        if (!reached) fail("timeout_program24");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
